scan_mux: RTL

Parametrised N-channel, W-bit registered multiplexer with two modes.
- Direct mode: the channel is chosen by a select input.
- Scan mode: a round-robin scanner steps through the enabled channels, waiting a programmable dwell time on each one.
- Each selected sample is presented on a valid/ready output port tagged with its channel index.
- Sits between banks of parallel sources and a single serial consumer.

---
 rtl/scan_mux_pkg.sv | 13 +
 rtl/scan_mux_next_ch.sv | 27 ++
 rtl/scan_mux.sv | 134 +++++++++++++
 3 files changed

// File: rtl/scan_mux_pkg.sv
// Shared mode constants and FSM state encoding for the scan/direct multiplexer.
package scan_mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/scan_mux_next_ch.sv
// Rotating priority finder: first enabled channel after ptr, wrapping, ptr itself last.
module scan_mux_next_ch #(
    parameter  int unsigned N_CH = 8,
    localparam int unsigned CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] ch_en,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] next_ch,
    output logic            found
);

    int unsigned idx;

    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx = (32'(ptr) + i) % N_CH;
            if (!found && ch_en[CH_W'(idx)]) begin
                found   = 1'b1;
                next_ch = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/scan_mux.sv
// N-channel registered multiplexer: direct select or round-robin scan with dwell,
// presenting each captured sample on a valid/ready port tagged with its channel.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int unsigned N_CH    = 8,
    parameter  int unsigned W       = 8,
    parameter  int unsigned DWELL_W = 4,
    localparam int unsigned CH_W    = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] ch_data,
    input  logic [N_CH-1:0]   ch_en,
    input  logic              mode,
    input  logic [CH_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [W-1:0]      out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned PAD = 1 << CH_W;

    state_t             state, state_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [CH_W-1:0]    ptr, ptr_nxt;
    logic [CH_W-1:0]    cur, cur_nxt;
    logic [W-1:0]       out_data_nxt;
    logic [CH_W-1:0]    out_ch_nxt;
    logic               out_valid_nxt;

    logic [PAD-1:0]     en_pad;
    logic               sel_ok;
    logic [CH_W-1:0]    scan_next;
    logic               scan_found;

    // Zero-padding makes out-of-range selects (non-power-of-2 N_CH) read as disabled.
    assign en_pad = PAD'(ch_en);
    assign sel_ok = en_pad[sel];

    scan_mux_next_ch #(.N_CH(N_CH)) u_next (
        .ch_en   (ch_en),
        .ptr     (ptr),
        .next_ch (scan_next),
        .found   (scan_found)
    );

    function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] data,
                                          input logic [CH_W-1:0]   idx);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (32'(idx) == c) r = data[c*W +: W];
        end
        return r;
    endfunction

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ptr_nxt      = ptr;
        cur_nxt      = cur;
        out_data_nxt = out_data;
        out_ch_nxt   = out_ch;
        case (state)
            IDLE: begin
                if (mode == MODE_DIRECT) begin
                    if (sel_ok) begin
                        out_data_nxt = pick(ch_data, sel);
                        out_ch_nxt   = sel;
                        state_nxt    = EMIT;
                    end
                end else if (scan_found) begin
                    cur_nxt   = scan_next;
                    ptr_nxt   = scan_next;
                    cnt_nxt   = dwell;
                    state_nxt = DWELL;
                end
            end
            DWELL: begin
                if (!en_pad[cur] || mode == MODE_DIRECT) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    out_data_nxt = pick(ch_data, cur);
                    out_ch_nxt   = cur;
                    state_nxt    = EMIT;
                end else begin
                    cnt_nxt = cnt - DWELL_W'(1);
                end
            end
            EMIT: begin
                // Held sample is untouched until the consumer takes it.
                if (out_ready) begin
                    if (mode == MODE_DIRECT && sel_ok) begin
                        out_data_nxt = pick(ch_data, sel);
                        out_ch_nxt   = sel;
                    end else if (mode == MODE_SCAN && scan_found) begin
                        cur_nxt   = scan_next;
                        ptr_nxt   = scan_next;
                        cnt_nxt   = dwell;
                        state_nxt = DWELL;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        out_valid_nxt = (state_nxt == EMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= CH_W'(N_CH - 1);
            cur       <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ptr       <= ptr_nxt;
            cur       <= cur_nxt;
            out_data  <= out_data_nxt;
            out_ch    <= out_ch_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule
